// File: rtl/ece423_timer_pkg.sv
// ece423_timer_pkg
// Shared definitions for the interval-timer host: the timer's register map,
// control/status bit positions, the host FSM state encoding and the period
// value the host assumes the timer holds out of reset.
package ece423_timer_pkg;

    // Timer register indices (16-bit register slave)
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    // STATUS bits
    localparam int STS_TO  = 0;
    localparam int STS_RUN = 1;

    // CONTROL bits
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [31:0] RESET_PERIOD = 32'h0001_E847;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_WR_STOP,
        S_CLR_ST,
        S_POLL_A,
        S_POLL_D,
        S_SNAP_WR,
        S_SNAP_LA,
        S_SNAP_LD,
        S_SNAP_HA,
        S_SNAP_HD
    } state_t;

endpackage

// File: rtl/ece423_timer_host.sv
// ece423_timer_host
// Avalon-MM initiator that owns the interval timer. It programs period and
// control, services timeouts by interrupt or by polling the STATUS register,
// counts serviced timeouts, and reads counter snapshots on request.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   m_address/m_chipselect/m_write_n/m_writedata : bus to the timer slave
//   m_readdata          : timer read data, valid one cycle after the address
//   irq                 : timer interrupt (level)
//   cfg_valid/cfg_ready : configure handshake; cfg_period, cfg_continuous,
//                         cfg_irq_en are latched on accept
//   stop_req, snap_req  : one-cycle request pulses (held pending until served)
//   snap_valid/snap_value : snapshot result, one-cycle pulse
//   tick, tick_count    : one pulse and one count per serviced timeout
//   running             : host-side copy of the timer run state
module ece423_timer_host
    import ece423_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [2:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [15:0]      m_writedata,
    input  logic [15:0]      m_readdata,
    input  logic             irq,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_continuous,
    input  logic             cfg_irq_en,
    input  logic             stop_req,
    input  logic             snap_req,
    output logic             snap_valid,
    output logic [31:0]      snap_value,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             running
);

    state_t           r_state;
    state_t           w_next;
    logic             r_alive;
    logic [31:0]      r_period;
    logic             r_cont;
    logic             r_irq_en;
    logic             r_stop_pend;
    logic             r_snap_pend;
    logic             r_running;
    logic [CNT_W-1:0] r_tick_count;
    logic [15:0]      r_snap_lo;
    logic [31:0]      r_snap_value;
    logic             r_snap_valid;

    logic             w_stop_pend;
    logic             w_snap_pend;
    logic             w_irq_svc;
    logic             w_cfg_accept;

    // A request pulse arriving in IDLE is served the same cycle.
    assign w_stop_pend  = r_stop_pend | stop_req;
    assign w_snap_pend  = r_snap_pend | snap_req;
    assign w_irq_svc    = irq & r_irq_en;

    // Ready only when the configure sequence would actually be chosen, so an
    // accepted configuration is never dropped by a higher-priority branch.
    assign cfg_ready    = r_alive && (r_state == S_IDLE) && !w_irq_svc && !w_stop_pend;
    assign w_cfg_accept = cfg_valid && cfg_ready;

    assign tick       = (r_state == S_CLR_ST);
    assign tick_count = r_tick_count;
    assign running    = r_running;
    assign snap_valid = r_snap_valid;
    assign snap_value = r_snap_value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore bus outputs
    always_comb begin
        w_next       = r_state;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = ADDR_STATUS;
        m_writedata  = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (w_irq_svc)                       w_next = S_CLR_ST;
                else if (w_stop_pend)                w_next = S_WR_STOP;
                else if (w_cfg_accept)               w_next = S_WR_PL;
                else if (w_snap_pend)                w_next = S_SNAP_WR;
                else if (r_running && !r_irq_en)     w_next = S_POLL_A;
            end
            S_WR_PL: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_PERIODL;
                m_writedata  = r_period[15:0];
                w_next       = S_WR_PH;
            end
            S_WR_PH: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_PERIODH;
                m_writedata  = r_period[31:16];
                w_next       = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_CONTROL;
                m_writedata  = 16'h0000;
                m_writedata[CTRL_START] = 1'b1;
                m_writedata[CTRL_CONT]  = r_cont;
                m_writedata[CTRL_ITO]   = r_irq_en;
                w_next       = S_IDLE;
            end
            S_WR_STOP: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_CONTROL;
                m_writedata  = 16'h0000;
                m_writedata[CTRL_STOP] = 1'b1;
                w_next       = S_IDLE;
            end
            S_CLR_ST: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_STATUS;
                w_next       = S_IDLE;
            end
            S_POLL_A: begin
                m_chipselect = 1'b1;
                m_address    = ADDR_STATUS;
                w_next       = S_POLL_D;
            end
            S_POLL_D: begin
                w_next = m_readdata[STS_TO] ? S_CLR_ST : S_IDLE;
            end
            S_SNAP_WR: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_SNAPL;
                w_next       = S_SNAP_LA;
            end
            S_SNAP_LA: begin
                m_chipselect = 1'b1;
                m_address    = ADDR_SNAPL;
                w_next       = S_SNAP_LD;
            end
            S_SNAP_LD: w_next = S_SNAP_HA;
            S_SNAP_HA: begin
                m_chipselect = 1'b1;
                m_address    = ADDR_SNAPH;
                w_next       = S_SNAP_HD;
            end
            S_SNAP_HD: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive      <= 1'b0;
            r_period     <= RESET_PERIOD;
            r_cont       <= 1'b0;
            r_irq_en     <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_snap_pend  <= 1'b0;
            r_running    <= 1'b0;
            r_tick_count <= '0;
            r_snap_lo    <= 16'h0000;
            r_snap_value <= 32'h0000_0000;
            r_snap_valid <= 1'b0;
        end else begin
            r_alive <= 1'b1;

            // Pending flags clear only when their own sequence is entered.
            r_stop_pend <= w_stop_pend && !((r_state == S_IDLE) && (w_next == S_WR_STOP));
            r_snap_pend <= w_snap_pend && !((r_state == S_IDLE) && (w_next == S_SNAP_WR));

            if (w_cfg_accept) begin
                r_period <= cfg_period;
                r_cont   <= cfg_continuous;
                r_irq_en <= cfg_irq_en;
            end

            if (r_state == S_WR_CTRL) begin
                r_running <= 1'b1;
            end else if (r_state == S_WR_STOP) begin
                r_running <= 1'b0;
            end else if ((r_state == S_CLR_ST) && !r_cont) begin
                r_running <= 1'b0;
            end

            if (r_state == S_CLR_ST) begin
                r_tick_count <= r_tick_count + 1'b1;
            end

            if (r_state == S_SNAP_LD) begin
                r_snap_lo <= m_readdata;
            end
            if (r_state == S_SNAP_HD) begin
                r_snap_value <= {m_readdata, r_snap_lo};
            end
            r_snap_valid <= (r_state == S_SNAP_HD);
        end
    end

endmodule

// File: doc/ece423_timer_host.md
# ece423_timer_host

Avalon-MM initiator that owns the interval-timer peripheral: it programs the period and control registers, services the timeout (by interrupt or by polling), and keeps a free-running tick count. It also captures counter snapshots on request. It sits between user logic and the timer's 16-bit register slave, so user logic never issues raw register accesses.

## Interface
- `CNT_W`, default 32: width of `tick_count`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `m_address` out 3: timer register index.
- `m_chipselect` out 1: access strobe.
- `m_write_n` out 1: low = write.
- `m_writedata` out 16: write data.
- `m_readdata` in 16: timer read data, registered in the timer, valid 1 cycle after address.
- `irq` in 1: timer interrupt, level.
- `cfg_valid` / `cfg_ready` in / out 1: configure handshake.
- `cfg_period` in 32: timeout period in clocks.
- `cfg_continuous` in 1: continuous mode.
- `cfg_irq_en` in 1: interrupt enable. When 0, the host polls.
- `stop_req` in 1: one-cycle pulse that stops the timer.
- `snap_req` in 1: one-cycle pulse that requests a snapshot.
- `snap_valid` out 1: one-cycle pulse.
- `snap_value` out 32: captured counter value.
- `tick` out 1: one-cycle pulse per serviced timeout.
- `tick_count` out CNT_W: number of serviced timeouts, wraps.
- `running` out 1: host-side copy of the run state.

## Operation
- Register map: 0 STATUS (bit0 timeout, bit1 run); 1 CONTROL (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP); 2 PERIODL; 3 PERIODH; 4 SNAPL; 5 SNAPH.
- The FSM is Moore: bus outputs decode from the current state only. In IDLE, `m_chipselect`=0 and `m_write_n`=1.
- Reset values:
  - all outputs 0, except `m_write_n`=1;
  - `cfg_ready`=0 in reset and 1 only in IDLE;
  - latched configuration: irq_en=0, cont=0.
- States:
  - IDLE
  - WR_PL, WR_PH, WR_CTRL
  - WR_STOP
  - CLR_ST
  - POLL_A, POLL_D
  - SNAP_WR, SNAP_LA, SNAP_LD, SNAP_HA, SNAP_HD
- IDLE arbitration, highest priority first:
  1. (`irq` and irq_en) → CLR_ST
  2. pending stop → WR_STOP
  3. `cfg_valid` → WR_PL
  4. pending snap → SNAP_WR
  5. (`running` and !irq_en) → POLL_A
- `stop_req` and `snap_req` set sticky pending flags. A flag clears when its sequence starts, so a pulse arriving mid-sequence is never lost.
- Configure sequence:
  - Accept occurs on `cfg_valid && cfg_ready`; latch period, cont and irq_en.
  - WR_PL writes period[15:0] to addr 2.
  - WR_PH writes period[31:16] to addr 3.
  - WR_CTRL writes {0,1,cont,irq_en} (START) to addr 1 and sets `running`=1.
  - Writes are back-to-back, 3 cycles. In the timer, START coincides with the period-write force-reload and wins.
- WR_STOP writes 4'b1000 to addr 1 and clears `running`.
- CLR_ST:
  - writes 0 to addr 0;
  - pulses `tick` and increments `tick_count` mod 2^CNT_W;
  - if cont=0, clears `running` (one-shot finished).
- Poll sequence:
  - POLL_A drives addr 0 with chipselect=1, write_n=1.
  - POLL_D samples `m_readdata[0]`. If 1 → CLR_ST, else → IDLE.
- Snapshot sequence:
  - SNAP_WR writes 0 to addr 4.
  - SNAP_LA/SNAP_LD read addr 4 and capture the low half in LD.
  - SNAP_HA/SNAP_HD read addr 5 and capture the high half in HD.
  - `snap_valid` pulses the cycle after HD.
- Timeouts during a sequence: the timer latches only one timeout flag, so multiple timeouts during a long sequence count as one tick. This is accepted behaviour.
- `cfg_valid` while a sequence is in progress waits (`cfg_ready`=0).
- Reset mid-sequence: the FSM returns to IDLE, pending flags clear, and the bus deasserts asynchronously.

## Timing
- Configure: 3 bus cycles. `cfg_ready` returns the cycle after WR_CTRL.
- IRQ service:
  - `irq` seen in IDLE at cycle N; the CLR_ST write happens in N+1.
  - The timer drops `irq` by N+2, and IDLE at N+2 sees it low, so there is no double count.
  - `tick` is high in N+1.
- Poll: 2 cycles for a negative result, 3 for a hit.
- Snapshot: `snap_req` at N gives `snap_valid` at N+6 when IDLE is free at N+1.
- No bus wait states. The timer never stalls.

## Structure
- Package `ece423_timer_pkg`: register address localparams, control bit positions, the FSM state enum, and reset period 32'h1E847.
- Single module, no sub-modules. The pending-flag logic and tick counter are inline.

## Test plan
- Configure with period=1000, cont=1, irq_en=1 against the timer model → bus writes 0x03E8@2, 0x0000@3, 0x0007@1. `irq` at ~1001 clocks, `tick_count` increments every 1001 clocks.
- One-shot (cont=0, period=50) → exactly one `tick`, then `running`=0, and `tick_count` stays at 1 for 500 cycles.
- Polling mode (irq_en=0, period=200) → repeated addr-0 reads, one CLR_ST per timeout, `tick_count`=5 after ~1005 cycles.
- `snap_req` 100 cycles after start with period=1000 → `snap_value` ≈ 900 (±8), and `snap_valid` arrives 6 cycles after the request.
- `irq` and `stop_req` and `cfg_valid` in the same cycle → CLR_ST first, then WR_STOP, then the configure sequence. No request is lost.
- Assert `reset_n` during WR_PH → bus is idle immediately, with `tick_count`=0 and `running`=0. After release, a new configure completes normally.
- Preload `tick_count` with 0xFFFFFFFF and service one IRQ → count wraps to 0.
